// File: rtl/can_pkg.sv
// Shared types and constants for the CAN frame-tail sequencer and its bit sampler.
package can_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CRC_DEL,
    S_ACK_SLOT,
    S_ACK_DEL,
    S_EOF,
    S_IFS
  } tail_state_t;

  typedef enum logic [1:0] {
    s_init,
    s_sample1,
    s_sample2,
    s_sample3
  } sample_state_t;

  localparam logic DOMINANT  = 1'b0;
  localparam logic RECESSIVE = 1'b1;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/can_tail_sequencer_if.sv
// Control, bus-drive and status bundle between the bit stream engine and the tail sequencer.
interface can_tail_sequencer_if;
  logic       start;
  logic       ackMode;
  logic       txPulse;
  logic       samplePulse;
  logic       rateSelector;
  logic       dIn;
  logic       dOut;
  logic       busy;
  logic       tailDone;
  logic       ackError;
  logic       bitError;
  logic       formError;
  logic       overloadReq;
  logic       hardSyncSof;
  logic [7:0] tailState;

  modport master (
    output start, ackMode, txPulse, samplePulse, rateSelector, dIn,
    input  dOut, busy, tailDone, ackError, bitError, formError, overloadReq,
           hardSyncSof, tailState
  );

  modport slave (
    input  start, ackMode, txPulse, samplePulse, rateSelector, dIn,
    output dOut, busy, tailDone, ackError, bitError, formError, overloadReq,
           hardSyncSof, tailState
  );
endinterface

// File: rtl/can_bit_sampler.sv
// Votes one bus bit from 1 or 3 sample strobes; bitValid is high the cycle after the last sample.
// No backpressure: a strobe arriving during the bitValid cycle starts the next bit.
module can_bit_sampler
  import can_pkg::*;
(
  input  logic          clk,
  input  logic          resetN,
  input  logic          samplePulse,
  input  logic          rateSelector,
  input  logic          dIn,
  input  logic          clear,
  output logic          bitValid,
  output logic          bitVal,
  output sample_state_t state
);

  sample_state_t state_q, state_d;
  logic [1:0]    smp_q, smp_d;
  logic          val_q, val_d;

  always_comb begin
    state_d = state_q;
    smp_d   = smp_q;
    val_d   = val_q;
    if (clear) begin
      state_d = s_init;
    end else if (samplePulse) begin
      case (state_q)
        s_sample1: begin
          smp_d[1] = dIn;
          state_d  = s_sample2;
        end
        s_sample2: begin
          val_d   = majority3(smp_q[0], smp_q[1], dIn);
          state_d = s_sample3;
        end
        default: begin
          // s_sample3 doubles as the bitValid cycle, so a strobe here opens the next bit
          if (rateSelector) begin
            smp_d[0] = dIn;
            state_d  = s_sample1;
          end else begin
            val_d   = dIn;
            state_d = s_sample3;
          end
        end
      endcase
    end else if (state_q == s_sample3) begin
      state_d = s_init;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q <= s_init;
      smp_q   <= 2'b00;
      val_q   <= RECESSIVE;
    end else begin
      state_q <= state_d;
      smp_q   <= smp_d;
      val_q   <= val_d;
    end
  end

  assign bitValid = (state_q == s_sample3);
  assign bitVal   = val_q;
  assign state    = state_q;

endmodule

// File: rtl/can_tail_sequencer.sv
// Drives/monitors CRC delimiter, ACK, ACK delimiter, EOF and intermission; flags pulse on the bitValid cycle.
// dOut is registered and changes only on txPulse; start is ignored while a tail is in progress.
module can_tail_sequencer
  import can_pkg::*;
#(
  parameter int EOF_BITS = 7,
  parameter int IFS_BITS = 3
) (
  input  logic                 clk,
  input  logic                 resetN,
  can_tail_sequencer_if.slave  bus
);

  localparam logic [2:0] EOF_LAST = 3'(EOF_BITS - 1);
  localparam logic [2:0] IFS_LAST = 3'(IFS_BITS - 1);

  tail_state_t   seq_q, seq_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          ack_mode_q, ack_mode_d;
  logic          dout_q, dout_d;
  logic          form_err, ack_err, bit_err, ovl_req, hard_sync, tail_done;
  logic          bit_valid, bit_val, smp_clear;
  sample_state_t smp_state;

  assign smp_clear = (seq_q == S_IDLE);

  can_bit_sampler u_sampler (
    .clk          (clk),
    .resetN       (resetN),
    .samplePulse  (bus.samplePulse),
    .rateSelector (bus.rateSelector),
    .dIn          (bus.dIn),
    .clear        (smp_clear),
    .bitValid     (bit_valid),
    .bitVal       (bit_val),
    .state        (smp_state)
  );

  always_comb begin
    seq_d      = seq_q;
    bit_cnt_d  = bit_cnt_q;
    ack_mode_d = ack_mode_q;
    dout_d     = dout_q;
    form_err   = 1'b0;
    ack_err    = 1'b0;
    bit_err    = 1'b0;
    ovl_req    = 1'b0;
    hard_sync  = 1'b0;
    tail_done  = 1'b0;

    // drive decision uses the state before any same-cycle transition
    if (bus.txPulse)
      dout_d = (seq_q == S_ACK_SLOT && ack_mode_q) ? DOMINANT : RECESSIVE;

    if (seq_q == S_IDLE) begin
      if (bus.start) begin
        seq_d      = S_CRC_DEL;
        ack_mode_d = bus.ackMode;
      end
    end else if (bit_valid) begin
      case (seq_q)
        S_CRC_DEL: begin
          if (bit_val == DOMINANT) begin
            form_err = 1'b1;
            seq_d    = S_IDLE;
          end else begin
            seq_d = S_ACK_SLOT;
          end
        end
        S_ACK_SLOT: begin
          if (bit_val == RECESSIVE) begin
            bit_err = ack_mode_q;
            ack_err = !ack_mode_q;
            seq_d   = S_IDLE;
          end else begin
            seq_d = S_ACK_DEL;
          end
        end
        S_ACK_DEL: begin
          if (bit_val == DOMINANT) begin
            form_err = 1'b1;
            seq_d    = S_IDLE;
          end else begin
            seq_d     = S_EOF;
            bit_cnt_d = 3'd0;
          end
        end
        S_EOF: begin
          if (bit_val == DOMINANT) begin
            ovl_req  = (bit_cnt_q == EOF_LAST);
            form_err = (bit_cnt_q != EOF_LAST);
            seq_d    = S_IDLE;
          end else if (bit_cnt_q == EOF_LAST) begin
            seq_d     = S_IFS;
            bit_cnt_d = 3'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        S_IFS: begin
          if (bit_val == DOMINANT) begin
            hard_sync = (bit_cnt_q == IFS_LAST);
            ovl_req   = (bit_cnt_q != IFS_LAST);
            seq_d     = S_IDLE;
          end else if (bit_cnt_q == IFS_LAST) begin
            tail_done = 1'b1;
            seq_d     = S_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        default: seq_d = S_IDLE;
      endcase
    end

    if (seq_d == S_IDLE)
      bit_cnt_d = 3'd0;
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      seq_q      <= S_IDLE;
      bit_cnt_q  <= 3'd0;
      ack_mode_q <= 1'b0;
      dout_q     <= RECESSIVE;
    end else begin
      seq_q      <= seq_d;
      bit_cnt_q  <= bit_cnt_d;
      ack_mode_q <= ack_mode_d;
      dout_q     <= dout_d;
    end
  end

  // flags are decoded from flops; gating with resetN keeps an aborted tail silent
  assign bus.formError   = form_err  & resetN;
  assign bus.ackError    = ack_err   & resetN;
  assign bus.bitError    = bit_err   & resetN;
  assign bus.overloadReq = ovl_req   & resetN;
  assign bus.hardSyncSof = hard_sync & resetN;
  assign bus.tailDone    = tail_done & resetN;
  assign bus.dOut        = dout_q;
  assign bus.busy        = (seq_q != S_IDLE);
  assign bus.tailState   = {smp_state, seq_q, bit_cnt_q};

endmodule

// File: tb/tb_can_tail_sequencer.sv
// Randomized scoreboard bench: a bit-position model of the frame tail predicts each tail's single outcome pulse.
module tb_can_tail_sequencer;

  localparam int EOF_N  = 7;
  localparam int IFS_N  = 3;
  localparam int NBITS  = 3 + EOF_N + IFS_N;
  localparam int EOF_LP = 2 + EOF_N;
  localparam logic [12:0] IDEAL = 13'b1_1111_1111_1101;

  localparam logic [5:0] EV_ACK  = 6'b000001;
  localparam logic [5:0] EV_BIT  = 6'b000010;
  localparam logic [5:0] EV_FORM = 6'b000100;
  localparam logic [5:0] EV_OVL  = 6'b001000;
  localparam logic [5:0] EV_HSYN = 6'b010000;
  localparam logic [5:0] EV_DONE = 6'b100000;

  typedef struct {
    logic [5:0] code;
    int         pos;
  } ev_t;

  logic clk = 1'b0;
  logic resetN;
  int   vectors = 0;
  int   miscompares = 0;
  int   cur_bit = -1;
  ev_t  exp_q[$];

  can_tail_sequencer_if bus ();

  can_tail_sequencer #(.EOF_BITS(EOF_N), .IFS_BITS(IFS_N)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s bit=%0d got %0h want %0h", name, cur_bit, got, want);
    end
  endtask

  // Walk the 13 tail bits; the first bit that breaks the frame rules decides the outcome.
  function automatic void model(input logic am, input logic [12:0] bv,
                                output int pos, output logic [5:0] ev);
    pos = NBITS - 1;
    ev  = EV_DONE;
    for (int p = 0; p < NBITS; p++) begin
      pos = p;
      if (p == 0 && !bv[p]) begin ev = EV_FORM; return; end
      if (p == 1 && bv[p])  begin ev = am ? EV_BIT : EV_ACK; return; end
      if (p == 2 && !bv[p]) begin ev = EV_FORM; return; end
      if (p >= 3 && p <= EOF_LP && !bv[p]) begin
        ev = (p == EOF_LP) ? EV_OVL : EV_FORM; return;
      end
      if (p > EOF_LP && !bv[p]) begin
        ev = (p == NBITS - 1) ? EV_HSYN : EV_OVL; return;
      end
    end
  endfunction

  // Debug word expected at the start of bit p: sampler idle, field state, position in field.
  function automatic logic [7:0] exp_state(input int p);
    int seq, cnt;
    if (p < 3)            begin seq = p + 1; cnt = 0; end
    else if (p <= EOF_LP) begin seq = 4; cnt = p - 3; end
    else                  begin seq = 5; cnt = p - EOF_LP - 1; end
    return {2'b00, 3'(seq), 3'(cnt)};
  endfunction

  task automatic monitor();
    logic [5:0] f;
    ev_t        e;
    forever begin
      @(negedge clk);
      f = {bus.tailDone, bus.hardSyncSof, bus.overloadReq, bus.formError, bus.bitError, bus.ackError};
      if (f !== 6'd0) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_flags got %b at bit %0d want none", f, cur_bit);
        end else begin
          e = exp_q.pop_front();
          if (f !== e.code || cur_bit != e.pos) begin
            miscompares++;
            $display("FAIL tail_event got %b at bit %0d want %b at bit %0d", f, cur_bit, e.code, e.pos);
          end
        end
      end
    end
  endtask

  task automatic send_samples(input logic v, input logic rate, input int flip_sel);
    int n, fl;
    n  = rate ? 3 : 1;
    fl = rate ? ((flip_sel >= 0) ? flip_sel : $urandom_range(0, 4)) : 9;
    for (int k = 0; k < n; k++) begin
      bus.dIn         = (k == fl) ? ~v : v;
      bus.samplePulse = 1'b1;
      tick();
      bus.samplePulse = 1'b0;
      bus.dIn         = 1'($urandom);
      if (k < n - 1) repeat ($urandom_range(1, 2)) tick();
    end
  endtask

  task automatic run_tail(input logic am, input logic rate, input logic [12:0] bv,
                          input int rst_at, input int flip_sel);
    int         endp;
    logic [5:0] ev;
    logic       exp_d;
    model(am, bv, endp, ev);
    if (rst_at < 0) exp_q.push_back('{code: ev, pos: endp});
    else endp = rst_at;
    exp_d = 1'b1;
    bus.rateSelector = rate;
    cur_bit = -1;
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    bus.start   = 1'b1;
    bus.ackMode = am;
    tick();
    bus.start   = 1'b0;
    bus.ackMode = 1'($urandom);
    for (int p = 0; p <= endp; p++) begin
      cur_bit = p;
      @(negedge clk);
      chk("bit_start_state", 32'(bus.tailState), 32'(exp_state(p)));
      chk("dout_hold", 32'(bus.dOut), 32'(exp_d));
      if (p == 1) begin
        bus.start   = 1'b1;
        bus.ackMode = ~am;
        tick();
        bus.start = 1'b0;
        @(negedge clk);
        chk("start_ignored", 32'(bus.tailState), 32'(exp_state(1)));
      end
      bus.txPulse = 1'b1;
      tick();
      bus.txPulse = 1'b0;
      exp_d = (p == 1 && am) ? 1'b0 : 1'b1;
      @(negedge clk);
      chk("dout", 32'(bus.dOut), 32'(exp_d));
      chk("busy", 32'(bus.busy), 32'd1);
      send_samples(bv[p], rate, (p == 1) ? flip_sel : -1);
      if (p == rst_at) resetN = 1'b0;
      tick();
      if (p == rst_at) begin
        resetN = 1'b1;
        @(negedge clk);
        chk("rst_state", 32'(bus.tailState), 32'd0);
        chk("rst_dout", 32'(bus.dOut), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_no_event", 32'(exp_q.size()), 32'd0);
        return;
      end
      if (p == endp) begin
        @(negedge clk);
        chk("end_busy", 32'(bus.busy), 32'd0);
        chk("end_state", 32'(bus.tailState), 32'd0);
      end else begin
        repeat ($urandom_range(0, 2)) tick();
      end
    end
    cur_bit = -1;
    bus.txPulse = 1'b1;
    tick();
    bus.txPulse = 1'b0;
    @(negedge clk);
    chk("dout_recover", 32'(bus.dOut), 32'd1);
    chk("event_seen", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [12:0] bv;
    logic        am, rate;
    resetN           = 1'b0;
    bus.start        = 1'b0;
    bus.ackMode      = 1'b0;
    bus.txPulse      = 1'b0;
    bus.samplePulse  = 1'b0;
    bus.rateSelector = 1'b1;
    bus.dIn          = 1'b1;
    fork
      monitor();
    join_none
    repeat (3) tick();
    @(negedge clk);
    chk("reset_dout", 32'(bus.dOut), 32'd1);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_state", 32'(bus.tailState), 32'd0);
    chk("reset_flags", 32'({bus.tailDone, bus.hardSyncSof, bus.overloadReq,
                            bus.formError, bus.bitError, bus.ackError}), 32'd0);
    tick();
    resetN = 1'b1;
    repeat (2) tick();

    run_tail(1'b0, 1'b1, IDEAL, -1, -1);                 // transmitter, acknowledged
    run_tail(1'b1, 1'b0, IDEAL, -1, -1);                 // receiver drives ACK
    bv = IDEAL; bv[1] = 1'b1;
    run_tail(1'b0, 1'b1, bv, -1, 2);                     // ACK samples 1,1,0
    run_tail(1'b1, 1'b1, bv, -1, -1);                    // receiver reads back recessive
    bv = IDEAL; bv[0] = 1'b0;  run_tail(1'b0, 1'b0, bv, -1, -1);
    bv = IDEAL; bv[2] = 1'b0;  run_tail(1'b0, 1'b1, bv, -1, -1);
    bv = IDEAL; bv[5] = 1'b0;  run_tail(1'b0, 1'b1, bv, -1, -1);   // EOF bit 3
    bv = IDEAL; bv[9] = 1'b0;  run_tail(1'b1, 1'b0, bv, -1, -1);   // EOF bit 7
    bv = IDEAL; bv[11] = 1'b0; run_tail(1'b0, 1'b1, bv, -1, -1);   // IFS bit 2
    bv = IDEAL; bv[12] = 1'b0; run_tail(1'b1, 1'b1, bv, -1, -1);   // IFS bit 3
    bv = IDEAL; bv[5] = 1'b0;  run_tail(1'b0, 1'b1, bv, 5, -1);    // reset during EOF
    repeat (2) tick();

    for (int i = 0; i < 40; i++) begin
      am   = 1'($urandom);
      rate = 1'($urandom);
      bv   = IDEAL;
      if ($urandom_range(0, 1) == 1) bv[$urandom_range(0, NBITS - 1)] ^= 1'b1;
      run_tail(am, rate, bv, -1, -1);
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
